axi4lite_arbiter: RTL

- Shares one AXI4-Lite slave port among NUM_M AXI4-Lite masters.
- Write and read channels are arbitrated independently; each allows one transaction in flight.
- A grant is held from address acceptance until the response handshake completes.
- Sits between the bus masters (DMA, CPU bridge) and the register-file slave; both sides are protocol-checked by the team's AXI4-Lite property monitor.

---
 rtl/axi4lite_arb_pkg.sv | 33 +++
 rtl/axi4lite_arb_core.sv | 84 ++++++++
 rtl/axi4lite_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite arbiter.
// Holds the FSM state encodings, the AXI4-Lite response codes and a
// lowest-set-bit helper used by the grant arbiter (supports up to 8 masters).
package axi4lite_arb_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] first_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axi4lite_arb_core.sv
// Registered grant arbiter: one instance serves the write FSM, one the read FSM.
// Grant is captured only while grant_en is high and some request is present.
// Build option AXI4LITE_ARB_RR_EN: round-robin starting after the last winner;
// without it, fixed priority with the lowest index winning.
module axi4lite_arb_core
    import axi4lite_arb_pkg::*;
#(
    parameter int NUM_M       = 2,
    parameter int GRANT_WIDTH = $clog2(NUM_M)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_M-1:0]       req,
    input  logic                   grant_en,
    output logic [NUM_M-1:0]       grant_oh,
    output logic [GRANT_WIDTH-1:0] grant_idx
);

    logic [7:0]             req_ext;
    logic [2:0]             pick;
    logic                   grant_fire;
    logic [NUM_M-1:0]       grant_oh_d;
    logic [NUM_M-1:0]       grant_oh_q;
    logic [GRANT_WIDTH-1:0] grant_idx_d;
    logic [GRANT_WIDTH-1:0] grant_idx_q;

    assign req_ext    = 8'(req);
    assign grant_fire = grant_en & (|req);

`ifdef AXI4LITE_ARB_RR_EN
    logic [GRANT_WIDTH-1:0] last_d;
    logic [GRANT_WIDTH-1:0] last_q;
    logic [7:0]             above_last;
    logic [7:0]             req_hi;

    // Requests above the last winner take precedence, otherwise wrap to the lowest index.
    always_comb begin
        above_last = '0;
        for (int i = 0; i < 8; i++) begin
            above_last[i] = (i > int'(last_q));
        end
        req_hi = req_ext & above_last;
        if (|req_hi) pick = first_set(req_hi);
        else         pick = first_set(req_ext);
        last_d = grant_fire ? GRANT_WIDTH'(pick) : last_q;
    end

    // Pointer remembers the most recent winner; reset points at the top master so index 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= GRANT_WIDTH'(NUM_M - 1);
        else        last_q <= last_d;
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb pick = first_set(req_ext);
`endif

    // Next grant: capture the pick on a fire, otherwise hold.
    always_comb begin
        grant_idx_d = grant_idx_q;
        grant_oh_d  = grant_oh_q;
        if (grant_fire) begin
            grant_idx_d = GRANT_WIDTH'(pick);
            for (int i = 0; i < NUM_M; i++) begin
                grant_oh_d[i] = (pick == 3'(i));
            end
        end
    end

    // Grant registers; the grant is never combinational from the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_idx_q <= '0;
            grant_oh_q  <= NUM_M'(1);
        end else begin
            grant_idx_q <= grant_idx_d;
            grant_oh_q  <= grant_oh_d;
        end
    end

    assign grant_oh  = grant_oh_q;
    assign grant_idx = grant_idx_q;

endmodule

// File: rtl/axi4lite_arbiter.sv
// AXI4-Lite N:1 arbiter. Write and read channels each own an FSM and a
// grant arbiter and keep one transaction in flight. The grant is held from
// address phase to response handshake; non-granted masters see no READY/VALID.
// Build option AXI4LITE_ARB_RR_EN selects round-robin instead of fixed priority.
//
// state   | meaning
// --------+----------------------------------------------------------
// WR_IDLE | no write owner; a pending AW or W registers a grant
// WR_ADDR | granted master's AW/W forwarded until both handshakes done
// WR_RESP | slave B routed to granted master until B handshake
// RD_IDLE | no read owner; a pending AR registers a grant
// RD_ADDR | granted master's AR forwarded until the AR handshake
// RD_RESP | slave R routed to granted master until R handshake
module axi4lite_arbiter
    import axi4lite_arb_pkg::*;
#(
    parameter int NUM_M      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    // master-facing ports
    input  logic [NUM_M-1:0]            S_AWVALID,
    output logic [NUM_M-1:0]            S_AWREADY,
    input  logic [NUM_M*ADDR_WIDTH-1:0] S_AWADDR,
    input  logic [NUM_M*3-1:0]          S_AWPROT,
    input  logic [NUM_M-1:0]            S_WVALID,
    output logic [NUM_M-1:0]            S_WREADY,
    input  logic [NUM_M*DATA_WIDTH-1:0] S_WDATA,
    input  logic [NUM_M*STRB_WIDTH-1:0] S_WSTRB,
    output logic [NUM_M-1:0]            S_BVALID,
    input  logic [NUM_M-1:0]            S_BREADY,
    output logic [NUM_M*2-1:0]          S_BRESP,
    input  logic [NUM_M-1:0]            S_ARVALID,
    output logic [NUM_M-1:0]            S_ARREADY,
    input  logic [NUM_M*ADDR_WIDTH-1:0] S_ARADDR,
    input  logic [NUM_M*3-1:0]          S_ARPROT,
    output logic [NUM_M-1:0]            S_RVALID,
    input  logic [NUM_M-1:0]            S_RREADY,
    output logic [NUM_M*DATA_WIDTH-1:0] S_RDATA,
    output logic [NUM_M*2-1:0]          S_RRESP,
    // slave-facing port
    output logic                        M_AWVALID,
    input  logic                        M_AWREADY,
    output logic [ADDR_WIDTH-1:0]       M_AWADDR,
    output logic [2:0]                  M_AWPROT,
    output logic                        M_WVALID,
    input  logic                        M_WREADY,
    output logic [DATA_WIDTH-1:0]       M_WDATA,
    output logic [STRB_WIDTH-1:0]       M_WSTRB,
    input  logic                        M_BVALID,
    output logic                        M_BREADY,
    input  logic [1:0]                  M_BRESP,
    output logic                        M_ARVALID,
    input  logic                        M_ARREADY,
    output logic [ADDR_WIDTH-1:0]       M_ARADDR,
    output logic [2:0]                  M_ARPROT,
    input  logic                        M_RVALID,
    output logic                        M_RREADY,
    input  logic [DATA_WIDTH-1:0]       M_RDATA,
    input  logic [1:0]                  M_RRESP
);

    localparam int GRANT_WIDTH = $clog2(NUM_M);

    wr_state_t              wr_state_d, wr_state_q;
    rd_state_t              rd_state_d, rd_state_q;
    logic                   aw_done_d, aw_done_q;
    logic                   w_done_d, w_done_q;

    logic [NUM_M-1:0]       wr_req, rd_req;
    logic [NUM_M-1:0]       wr_oh, rd_oh;
    logic [GRANT_WIDTH-1:0] wr_idx, rd_idx;
    logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // W may arrive before AW, so either valid counts as a write request.
    assign wr_req = S_AWVALID | S_WVALID;
    assign rd_req = S_ARVALID;

    axi4lite_arb_core #(
        .NUM_M       (NUM_M),
        .GRANT_WIDTH (GRANT_WIDTH)
    ) u_wr_arb (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .req       (wr_req),
        .grant_en  (wr_state_q == WR_IDLE),
        .grant_oh  (wr_oh),
        .grant_idx (wr_idx)
    );

    axi4lite_arb_core #(
        .NUM_M       (NUM_M),
        .GRANT_WIDTH (GRANT_WIDTH)
    ) u_rd_arb (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .req       (rd_req),
        .grant_en  (rd_state_q == RD_IDLE),
        .grant_oh  (rd_oh),
        .grant_idx (rd_idx)
    );

    // Write channel routing: only the granted master is connected, and only in its phase.
    always_comb begin
        M_AWVALID = 1'b0;
        M_AWADDR  = '0;
        M_AWPROT  = '0;
        M_WVALID  = 1'b0;
        M_WDATA   = '0;
        M_WSTRB   = '0;
        M_BREADY  = 1'b0;
        S_AWREADY = '0;
        S_WREADY  = '0;
        S_BVALID  = '0;
        S_BRESP   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (wr_state_q == WR_ADDR && wr_idx == GRANT_WIDTH'(i)) begin
                M_AWADDR = S_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                M_AWPROT = S_AWPROT[i*3 +: 3];
                M_WDATA  = S_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                M_WSTRB  = S_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
            end
            // Once a channel has handshaken it is masked so it cannot accept twice.
            if (wr_state_q == WR_ADDR && wr_oh[i]) begin
                M_AWVALID    = S_AWVALID[i] & ~aw_done_q;
                M_WVALID     = S_WVALID[i] & ~w_done_q;
                S_AWREADY[i] = M_AWREADY & ~aw_done_q;
                S_WREADY[i]  = M_WREADY & ~w_done_q;
            end
            if (wr_state_q == WR_RESP && wr_oh[i]) begin
                S_BVALID[i]      = M_BVALID;
                S_BRESP[i*2 +: 2] = M_BRESP;
                M_BREADY         = S_BREADY[i];
            end
        end
    end

    // Read channel routing, same scheme as the write side.
    always_comb begin
        M_ARVALID = 1'b0;
        M_ARADDR  = '0;
        M_ARPROT  = '0;
        M_RREADY  = 1'b0;
        S_ARREADY = '0;
        S_RVALID  = '0;
        S_RDATA   = '0;
        S_RRESP   = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (rd_state_q == RD_ADDR && rd_idx == GRANT_WIDTH'(i)) begin
                M_ARADDR = S_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                M_ARPROT = S_ARPROT[i*3 +: 3];
            end
            if (rd_state_q == RD_ADDR && rd_oh[i]) begin
                M_ARVALID    = S_ARVALID[i];
                S_ARREADY[i] = M_ARREADY;
            end
            if (rd_state_q == RD_RESP && rd_idx == GRANT_WIDTH'(i)) begin
                S_RDATA[i*DATA_WIDTH +: DATA_WIDTH] = M_RDATA;
                S_RRESP[i*2 +: 2]                   = M_RRESP;
            end
            if (rd_state_q == RD_RESP && rd_oh[i]) begin
                S_RVALID[i] = M_RVALID;
                M_RREADY    = S_RREADY[i];
            end
        end
    end

    assign aw_hs = M_AWVALID & M_AWREADY;
    assign w_hs  = M_WVALID & M_WREADY;
    assign b_hs  = M_BVALID & M_BREADY;
    assign ar_hs = M_ARVALID & M_ARREADY;
    assign r_hs  = M_RVALID & M_RREADY;

    // Write FSM: AW and W complete in either order before the response phase.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (|wr_req) wr_state_d = WR_ADDR;
            end
            WR_ADDR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs) begin
                    wr_state_d = WR_IDLE;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            default: begin
                wr_state_d = WR_IDLE;
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
            end
        endcase
    end

    // Read FSM: one AR then one R per grant.
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (|rd_req) rd_state_d = RD_ADDR;
            RD_ADDR: if (ar_hs)   rd_state_d = RD_RESP;
            RD_RESP: if (r_hs)    rd_state_d = RD_IDLE;
            default:              rd_state_d = RD_IDLE;
        endcase
    end

    // State registers; reset abandons any half-completed transfer.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

endmodule
